// File: rtl/btn_pkg.sv
// Shared definitions for the pushbutton debouncer: FSM encoding and default timing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package btn_pkg;

   // Debouncer states; encoding is fixed because other tooling decodes it.
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } btn_state_e;

   // Defaults sized for a 50 MHz board clock: 20 ms debounce, 1 s long press.
   localparam int unsigned DEB_CYCLES_DEFAULT  = 1_000_000;
   localparam int unsigned LONG_CYCLES_DEFAULT = 50_000_000;

   // The button counts as "down" once a press is accepted and until a release is.
   function automatic logic is_down(input btn_state_e st);
      return (st == HELD) || (st == DB_RELEASE);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous board input into the clk domain.
// Latency: 2 clk edges from d to q.
// Backpressure: none; free-running.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // First flop may go metastable; second flop gives it a full cycle to settle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/btn_debounce.sv
// Pushbutton debouncer: debounced level, press/release/long-press pulses, press counter.
// Latency: press_pulse/release_pulse high after edge k+DEB_CYCLES+2 (k = first edge sampling the new level).
// Backpressure: none; pulses are single-cycle and must be consumed when issued.
module btn_debounce
   import btn_pkg::*;
#(
   parameter int unsigned DEB_CYCLES  = DEB_CYCLES_DEFAULT,
   parameter int unsigned LONG_CYCLES = LONG_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       button,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic [7:0] press_cnt
);

   // Counters only ever need to reach their parameter minus one.
   localparam int unsigned DCW = $clog2(DEB_CYCLES);
   localparam int unsigned LCW = $clog2(LONG_CYCLES);
   localparam logic [DCW-1:0] DCNT_LAST = DCW'(DEB_CYCLES - 1);
   localparam logic [LCW-1:0] LCNT_LAST = LCW'(LONG_CYCLES - 1);

   logic           s;
   btn_state_e     state_q;
   logic [DCW-1:0] dcnt_q;
   logic [LCW-1:0] lcnt_q;
   logic           btn_level_q;
   logic           press_pulse_q;
   logic           release_pulse_q;
   logic           long_pulse_q;
   logic [7:0]     press_cnt_q;

   sync_2ff u_sync (
      .clk (clk),
      .rst (rst),
      .d   (button),
      .q   (s)
   );

   // Debounce FSM with all outputs registered; one dcnt serves both press and release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q         <= IDLE;
         dcnt_q          <= '0;
         lcnt_q          <= '0;
         btn_level_q     <= 1'b0;
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_pulse_q    <= 1'b0;
         press_cnt_q     <= 8'd0;
      end else begin
         press_pulse_q   <= 1'b0;
         release_pulse_q <= 1'b0;
         long_pulse_q    <= 1'b0;

         // Long-press timer keeps running through release bounces and saturates,
         // so the long pulse fires at most once per accepted press.
         if (is_down(state_q) && (lcnt_q != LCNT_LAST)) begin
            lcnt_q       <= lcnt_q + LCW'(1);
            long_pulse_q <= ((lcnt_q + LCW'(1)) == LCNT_LAST);
         end

         case (state_q)
            IDLE: begin
               if (s) begin
                  state_q <= DB_PRESS;
                  dcnt_q  <= '0;
               end
            end
            DB_PRESS: begin
               if (!s) begin
                  state_q <= IDLE;
               end else if (dcnt_q == DCNT_LAST) begin
                  state_q       <= HELD;
                  btn_level_q   <= 1'b1;
                  press_pulse_q <= 1'b1;
                  press_cnt_q   <= press_cnt_q + 8'd1;
                  lcnt_q        <= '0;
               end else begin
                  dcnt_q <= dcnt_q + DCW'(1);
               end
            end
            HELD: begin
               if (!s) begin
                  state_q <= DB_RELEASE;
                  dcnt_q  <= '0;
               end
            end
            DB_RELEASE: begin
               if (s) begin
                  state_q <= HELD;
               end else if (dcnt_q == DCNT_LAST) begin
                  state_q         <= IDLE;
                  btn_level_q     <= 1'b0;
                  release_pulse_q <= 1'b1;
               end else begin
                  dcnt_q <= dcnt_q + DCW'(1);
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign btn_level     = btn_level_q;
   assign press_pulse   = press_pulse_q;
   assign release_pulse = release_pulse_q;
   assign long_pulse    = long_pulse_q;
   assign press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_btn_debounce.sv
// Self-checking bench for btn_debounce: directed scenarios plus random button noise.
// Reference: streak-length model of the debounce rules, compared every cycle.
// Backpressure: n/a.
module tb_btn_debounce;

   localparam int unsigned DEB  = 8;
   localparam int unsigned LONG = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       button = 1'b0;
   logic       btn_level;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic [7:0] press_cnt;

   always #5 clk = ~clk;

   btn_debounce #(
      .DEB_CYCLES  (DEB),
      .LONG_CYCLES (LONG)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .button        (button),
      .btn_level     (btn_level),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse),
      .long_pulse    (long_pulse),
      .press_cnt     (press_cnt)
   );

   int n_vec = 0;
   int n_bad = 0;

   // Reference state: synchronizer pipe, accepted level, length of the current
   // disagreeing streak, cycles spent down since the last accepted press.
   bit m_pipe0, m_pipe1;
   bit m_level;
   int m_run;
   int m_held;
   int m_cnt;
   bit m_pp, m_rp, m_lp;

   // Scenario bookkeeping
   int cyc;
   int first_pp, first_rp, first_lp;
   int pp_seen, rp_seen, lp_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d, want %0d", tag, $time, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pipe0 = 0; m_pipe1 = 0; m_level = 0; m_run = 0;
      m_held = 0; m_cnt = 0; m_pp = 0; m_rp = 0; m_lp = 0;
   endtask

   // A new level is accepted once the synchronized input has disagreed with
   // the accepted level on DEB+1 consecutive edges.
   task automatic model_edge(input bit b);
      bit s;
      if (!rst) begin
         model_reset();
         return;
      end
      s       = m_pipe1;
      m_pipe1 = m_pipe0;
      m_pipe0 = b;
      m_pp = 0; m_rp = 0; m_lp = 0;
      if (m_level) begin
         m_held++;
         if (m_held == int'(LONG) - 1) m_lp = 1;
      end
      if (s != m_level) m_run++;
      else m_run = 0;
      if (m_run == int'(DEB) + 1) begin
         m_level = !m_level;
         m_run   = 0;
         if (m_level) begin
            m_pp   = 1;
            m_cnt  = (m_cnt + 1) % 256;
            m_held = 0;
         end else begin
            m_rp = 1;
         end
      end
   endtask

   task automatic compare_all();
      check("btn_level", btn_level, m_level);
      check("press_pulse", press_pulse, m_pp);
      check("release_pulse", release_pulse, m_rp);
      check("long_pulse", long_pulse, m_lp);
      check("press_cnt", press_cnt, m_cnt);
      check("press_and_release", press_pulse & release_pulse, 0);
   endtask

   task automatic clear_marks();
      cyc = -1;
      first_pp = -1; first_rp = -1; first_lp = -1;
      pp_seen = 0; rp_seen = 0; lp_seen = 0;
   endtask

   // One clock: drive, clock edge, update model, sample 1 ns later, compare.
   task automatic tick(input bit b);
      button = b;
      @(posedge clk);
      model_edge(b);
      #1;
      cyc++;
      if (press_pulse) begin pp_seen++; if (first_pp < 0) first_pp = cyc; end
      if (release_pulse) begin rp_seen++; if (first_rp < 0) first_rp = cyc; end
      if (long_pulse) begin lp_seen++; if (first_lp < 0) first_lp = cyc; end
      compare_all();
   endtask

   task automatic ticks(input bit b, input int n);
      for (int i = 0; i < n; i++) tick(b);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      model_reset();
      clear_marks();
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      compare_all();
      rst = 1'b1;
      ticks(0, 4);

      // Clean press then clean release
      clear_marks();
      ticks(1, 14);
      check("clean_press_latency", first_pp, 10);
      check("clean_press_count", pp_seen, 1);
      check("clean_level", btn_level, 1);
      check("clean_cnt", press_cnt, 1);
      clear_marks();
      ticks(0, 14);
      check("clean_release_latency", first_rp, 10);

      // Bouncing press: 3-cycle toggles for 30 cycles, final rise at edge 30
      clear_marks();
      for (int i = 0; i < 30; i++) tick(((i / 3) % 2) == 0);
      check("bounce_no_early_press", pp_seen, 0);
      ticks(1, 16);
      check("bounce_press_count", pp_seen, 1);
      check("bounce_press_latency", first_pp, 40);
      ticks(0, 14);

      // Long press: 60 cycles held then released
      clear_marks();
      ticks(1, 60);
      ticks(0, 16);
      check("long_count", lp_seen, 1);
      check("long_edge", first_lp, 41);
      check("long_release_latency", first_rp, 70);
      check("long_release_count", rp_seen, 1);

      // Release bounce: 4-cycle drop while held, long timer must keep running
      clear_marks();
      ticks(1, 20);
      ticks(0, 4);
      ticks(1, 26);
      check("rbounce_no_release", rp_seen, 0);
      check("rbounce_level", btn_level, 1);
      check("rbounce_long_edge", first_lp, 41);
      ticks(0, 14);
      check("rbounce_release_latency", first_rp, 60);

      // Reset mid-debounce: dcnt is 5 after edge 7
      clear_marks();
      ticks(1, 8);
      rst = 1'b0;
      model_reset();
      #1;
      compare_all();
      check("midrst_no_pulse", pp_seen, 0);
      ticks(1, 3);
      rst = 1'b1;
      clear_marks();
      ticks(1, 14);
      check("midrst_press_latency", first_pp, 10);
      ticks(0, 14);

      // Wrap: 256 presses from a fresh reset
      rst = 1'b0;
      #1;
      model_reset();
      compare_all();
      rst = 1'b1;
      clear_marks();
      for (int p = 0; p < 256; p++) begin
         ticks(1, 12);
         ticks(0, 12);
      end
      check("wrap_pulses", pp_seen, 256);
      check("wrap_cnt", press_cnt, 0);

      // Random button noise with a mix of short bounces and long holds
      for (int seg = 0; seg < 150; seg++) begin
         bit b;
         int len;
         b   = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 45))
                                           : int'($urandom_range(1, 9));
         ticks(b, len);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/btn_debounce.md
BTN_DEBOUNCE -- requirements
Module: btn_debounce

Interface
REQ-001 SHALL have parameter DEB_CYCLES, default 1_000_000, meaning the number of stable clock cycles required to accept a press or a release; legal when >= 2.
REQ-002 SHALL have parameter LONG_CYCLES, default 50_000_000, meaning the number of cycles in HELD before a long press is flagged; legal when > DEB_CYCLES.
REQ-003 Port clk, input, 1 bit: the single clock.
REQ-004 Port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port button, input, 1 bit: raw asynchronous pushbutton, 1 = pressed.
REQ-006 Port btn_level, output, 1 bit: debounced level, 1 while in HELD or DB_RELEASE.
REQ-007 Port press_pulse, output, 1 bit: one-cycle pulse on each accepted press; this is the button input of the downstream memory write/read controller.
REQ-008 Port release_pulse, output, 1 bit: one-cycle pulse on each accepted release.
REQ-009 Port long_pulse, output, 1 bit: one-cycle pulse, issued at most once per press.
REQ-010 Port press_cnt, output, 8 bits: count of accepted presses.

Function
REQ-011 button SHALL pass through a 2-flop synchronizer; the output of the second flop is s, and the FSM uses only s.
REQ-012 FSM states SHALL be IDLE, DB_PRESS, HELD, DB_RELEASE, each with one shared debounce counter dcnt.
REQ-013 IDLE: when s=1, go to DB_PRESS and set dcnt=0.
REQ-014 DB_PRESS: when s=0, return to IDLE (bounce); when dcnt==DEB_CYCLES-1, go to HELD; otherwise increment dcnt.
REQ-015 HELD: when s=0, go to DB_RELEASE and set dcnt=0.
REQ-016 DB_RELEASE: when s=1, return to HELD; when dcnt==DEB_CYCLES-1, go to IDLE; otherwise increment dcnt.
REQ-017 press_pulse SHALL be a registered pulse, high for exactly the one cycle after the DB_PRESS->HELD edge.
- Stable input latency: high after edge k+DEB_CYCLES+2, where edge k is the first edge at which button is sampled 1.
REQ-018 release_pulse SHALL follow the same rule on the DB_RELEASE->IDLE edge, with the same latency.
REQ-019 Long-press counter lcnt SHALL clear on the DB_PRESS->HELD edge.
- It SHALL count every cycle spent in HELD or DB_RELEASE, and SHALL NOT clear on a DB_RELEASE->HELD bounce.
REQ-020 long_pulse SHALL assert for one cycle when lcnt reaches LONG_CYCLES-1; lcnt then saturates, so there is no repeat until the next press.
REQ-021 press_cnt SHALL increment in the same cycle press_pulse is high, and SHALL wrap from 255 to 0.
REQ-022 press_pulse and release_pulse SHALL never be high in the same cycle.
- long_pulse MAY coincide with release_pulse when release completes on the same edge.
REQ-023 A bounce shorter than DEB_CYCLES cycles SHALL produce no pulse and no change in btn_level.
REQ-024 All counters SHALL be sized with $clog2 of their parameter; there SHALL be no overflow for legal parameters.

Reset
REQ-025 While rst=0, the block SHALL hold:
- FSM in IDLE
- synchronizer flops, dcnt and lcnt at 0
- btn_level, press_pulse, release_pulse, long_pulse at 0
- press_cnt at 8'd0
REQ-026 Reset asserted mid-debounce or mid-HELD SHALL take effect immediately and SHALL emit no pulse.
REQ-027 After rst deasserts with button already held, the block SHALL debounce as a fresh press, with press_pulse following REQ-017 latency.

Structure
REQ-028 Package btn_pkg SHALL hold the state encoding (2-bit, IDLE=0, DB_PRESS=1, HELD=2, DB_RELEASE=3) and the default DEB_CYCLES and LONG_CYCLES constants.
REQ-029 The synchronizer SHALL be a separate sub-module, sync_2ff (clk, rst, d, q), reusable for other board inputs.
REQ-030 btn_debounce SHALL sit between the board button pin and the memory controller in the lab top level, clocked by the same clk_g.

Verification (DEB_CYCLES=8, LONG_CYCLES=32)
REQ-031 Clean press: hold button=1 from edge 0 -> press_pulse high for one cycle after edge 10, btn_level=1, press_cnt=1.
REQ-032 Bounce: on the press, toggle button 1/0 every 3 cycles for 30 cycles, then hold 1 -> exactly one press_pulse, 10 edges after the final rise.
REQ-033 Long press: hold button=1 for 60 cycles, then release -> one long_pulse, then one release_pulse 10 edges after the fall; no second long_pulse.
REQ-034 Release bounce: in HELD, drop button for 4 cycles, then restore -> no release_pulse, btn_level stays 1, lcnt continues counting.
REQ-035 Wrap: 256 clean presses -> press_cnt ends at 0, with 256 press_pulses counted.
REQ-036 Reset mid-op: assert rst=0 at dcnt=5 of DB_PRESS -> all outputs 0 immediately; after release of rst with button still 1 -> press_pulse after 10 edges.
